wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback logic. It is the block that drives the register-file write port: reg_write, rd and write_data.
- It selects between the ALU result and the memory load data, and extracts and extends LB/LBU/LH/LHU/LW data (big-endian).
- It provides a WB->ID bypass so a decode read in the same cycle as a write sees the new value.
- It counts retired instructions.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/wb_stage_load_align.sv | 53 +++++
 rtl/wb_stage.sv | 107 ++++++++++
 tb/tb_wb_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-I pipeline definitions: load encodings, the $zero register
// address and the MEM/WB pipeline register layout.
package mips_pkg;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic [2:0]  load_type;
        logic [1:0]  addr_lo;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  rd;
    } wb_reg_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Big-endian load lane extraction and sign/zero extension, plus alignment
// check. Purely combinational so the MEM stage can reuse it.
module load_align
    import mips_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Lane select (offset 0 is the most significant lane) and extension.
    always_comb begin
        half_s     = 16'h0000;
        byte_s     = 8'h00;
        data       = raw;
        misaligned = 1'b0;
        if (addr_lo[1]) begin
            half_s = raw[15:0];
        end else begin
            half_s = raw[31:16];
        end
        case (addr_lo)
            2'd0:    byte_s = raw[31:24];
            2'd1:    byte_s = raw[23:16];
            2'd2:    byte_s = raw[15:8];
            2'd3:    byte_s = raw[7:0];
            default: byte_s = raw[31:24];
        endcase
        case (load_type)
            LD_LW: begin
                data       = raw;
                misaligned = (addr_lo != 2'd0);
            end
            LD_LH: begin
                data       = {{16{half_s[15]}}, half_s};
                misaligned = addr_lo[0];
            end
            LD_LHU: begin
                data       = {16'h0000, half_s};
                misaligned = addr_lo[0];
            end
            LD_LB:   data = {{24{byte_s[7]}}, byte_s};
            LD_LBU:  data = {24'h000000, byte_s};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, register-file write port, WB->ID bypass and
// retired-instruction counter.
module wb_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_valid_i,
    input  logic          mem_reg_write_i,
    input  logic          mem_mem_to_reg_i,
    input  logic [2:0]    mem_load_type_i,
    input  logic [1:0]    mem_addr_lo_i,
    input  logic [DW-1:0] mem_alu_result_i,
    input  logic [DW-1:0] mem_read_data_i,
    input  logic [AW-1:0] mem_rd_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    output logic          reg_write_o,
    output logic [AW-1:0] rd_o,
    output logic [DW-1:0] write_data_o,
    output logic [DW-1:0] id_rs_data_o,
    output logic [DW-1:0] id_rt_data_o,
    output logic          misaligned_o,
    output logic          retire_o,
    output logic [31:0]   instret_o
);

    wb_reg_t     wb_r;
    logic [31:0] instret_r;
    logic [31:0] load_data_s;
    logic        load_mis_s;
    logic        misaligned_s;
    logic        wen_byp_s;
    logic        retire_s;

    load_align u_load_align (
        .load_type  (wb_r.load_type),
        .addr_lo    (wb_r.addr_lo),
        .raw        (wb_r.read_data),
        .data       (load_data_s),
        .misaligned (load_mis_s)
    );

    // Pipeline register and retire counter; flush has priority over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_r      <= '0;
            instret_r <= 32'h0000_0000;
        end else begin
            if (retire_s) begin
                instret_r <= instret_r + 32'd1;
            end
            if (flush) begin
                wb_r.valid <= 1'b0;
            end else if (!stall) begin
                wb_r <= '{valid:      mem_valid_i,
                          reg_write:  mem_reg_write_i,
                          mem_to_reg: mem_mem_to_reg_i,
                          load_type:  mem_load_type_i,
                          addr_lo:    mem_addr_lo_i,
                          alu_result: mem_alu_result_i,
                          read_data:  mem_read_data_i,
                          rd:         mem_rd_i};
            end
        end
    end

    // Write port, bypass and retire. The bypass ignores stall so a stalled
    // decode keeps seeing the pending value; reset forces every output low.
    always_comb begin
        misaligned_s = wb_r.valid & wb_r.mem_to_reg & load_mis_s;
        wen_byp_s    = wb_r.valid & wb_r.reg_write & (wb_r.rd != REG_ZERO) & ~misaligned_s;
        retire_s     = wb_r.valid & ~stall;
        reg_write_o  = wen_byp_s & ~stall;
        rd_o         = wb_r.rd;
        misaligned_o = misaligned_s;
        retire_o     = retire_s;
        instret_o    = instret_r;
        if (wb_r.mem_to_reg) begin
            write_data_o = load_data_s;
        end else begin
            write_data_o = wb_r.alu_result;
        end
        if (!rst_n) begin
            id_rs_data_o = 32'h0000_0000;
        end else if (wen_byp_s && (wb_r.rd == id_rs_i)) begin
            id_rs_data_o = write_data_o;
        end else begin
            id_rs_data_o = id_rs_data_i;
        end
        if (!rst_n) begin
            id_rt_data_o = 32'h0000_0000;
        end else if (wen_byp_s && (wb_r.rd == id_rt_i)) begin
            id_rt_data_o = write_data_o;
        end else begin
            id_rt_data_o = id_rt_data_i;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic        mem_valid_i, mem_reg_write_i, mem_mem_to_reg_i;
    logic [2:0]  mem_load_type_i;
    logic [1:0]  mem_addr_lo_i;
    logic [31:0] mem_alu_result_i, mem_read_data_i;
    logic [4:0]  mem_rd_i, id_rs_i, id_rt_i;
    logic [31:0] id_rs_data_i, id_rt_data_i;
    logic        reg_write_o, misaligned_o, retire_o;
    logic [4:0]  rd_o;
    logic [31:0] write_data_o, id_rs_data_o, id_rt_data_o, instret_o;

    int n_checks = 0;
    int n_err    = 0;
    logic cmp_en = 1'b0;

    // model of the WB register contents and retire count
    logic        m_valid, m_rw, m_m2r;
    logic [2:0]  m_lt;
    logic [1:0]  m_off;
    logic [31:0] m_alu, m_raw, m_cnt;
    logic [4:0]  m_rd;
    logic [31:0] m_adj = 32'h0;

    wb_stage #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid_i(mem_valid_i), .mem_reg_write_i(mem_reg_write_i),
        .mem_mem_to_reg_i(mem_mem_to_reg_i), .mem_load_type_i(mem_load_type_i),
        .mem_addr_lo_i(mem_addr_lo_i), .mem_alu_result_i(mem_alu_result_i),
        .mem_read_data_i(mem_read_data_i), .mem_rd_i(mem_rd_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .reg_write_o(reg_write_o), .rd_o(rd_o), .write_data_o(write_data_o),
        .id_rs_data_o(id_rs_data_o), .id_rt_data_o(id_rt_data_o),
        .misaligned_o(misaligned_o), .retire_o(retire_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_data();
        logic [31:0] v;
        int lane;
        if (!m_m2r) return m_alu;
        case (m_lt)
            3'd1, 3'd2: begin
                v = (m_raw >> (m_off[1] ? 0 : 16)) & 32'h0000_FFFF;
                if (m_lt == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                return v;
            end
            3'd3, 3'd4: begin
                lane = 3 - int'(m_off);
                v = (m_raw >> (8 * lane)) & 32'h0000_00FF;
                if (m_lt == 3'd3 && v[7]) v = v | 32'hFFFF_FF00;
                return v;
            end
            default: return m_raw;
        endcase
    endfunction

    function automatic logic ref_mis();
        return m_valid && m_m2r &&
               ((m_lt == 3'd0 && m_off != 2'd0) ||
                ((m_lt == 3'd1 || m_lt == 3'd2) && m_off[0]));
    endfunction

    // Model state update at each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_m2r <= 1'b0; m_lt <= 3'd0; m_off <= 2'd0;
            m_alu <= 32'h0; m_raw <= 32'h0; m_rd <= 5'd0; m_cnt <= 32'h0;
        end else begin
            if (m_valid && !stall) m_cnt <= m_cnt + 32'd1;
            if (flush) m_valid <= 1'b0;
            else if (!stall) begin
                m_valid <= mem_valid_i; m_rw <= mem_reg_write_i; m_m2r <= mem_mem_to_reg_i;
                m_lt <= mem_load_type_i; m_off <= mem_addr_lo_i; m_alu <= mem_alu_result_i;
                m_raw <= mem_read_data_i; m_rd <= mem_rd_i;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] e_wd, e_rs, e_rt;
            logic e_mis, e_wen;
            e_wd  = rst_n ? ref_data() : 32'h0;
            e_mis = rst_n && ref_mis();
            e_wen = rst_n && m_valid && m_rw && (m_rd != 5'd0) && !e_mis;
            e_rs  = !rst_n ? 32'h0 : ((e_wen && m_rd == id_rs_i) ? e_wd : id_rs_data_i);
            e_rt  = !rst_n ? 32'h0 : ((e_wen && m_rd == id_rt_i) ? e_wd : id_rt_data_i);
            chk("m_reg_write", {31'h0, reg_write_o}, {31'h0, e_wen && !stall});
            chk("m_rd", {27'h0, rd_o}, rst_n ? {27'h0, m_rd} : 32'h0);
            chk("m_write_data", write_data_o, e_wd);
            chk("m_misaligned", {31'h0, misaligned_o}, {31'h0, e_mis});
            chk("m_retire", {31'h0, retire_o}, {31'h0, rst_n && m_valid && !stall});
            chk("m_instret", instret_o, rst_n ? (m_cnt + m_adj) : 32'h0);
            chk("m_rs_byp", id_rs_data_o, e_rs);
            chk("m_rt_byp", id_rt_data_o, e_rt);
        end
    end

    task automatic mi(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                      input logic [1:0] off, input logic [31:0] alu, input logic [31:0] raw,
                      input logic [4:0] rd);
        mem_valid_i = v; mem_reg_write_i = rw; mem_mem_to_reg_i = m2r; mem_load_type_i = lt;
        mem_addr_lo_i = off; mem_alu_result_i = alu; mem_read_data_i = raw; mem_rd_i = rd;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        id_rs_i = 5'd0; id_rt_i = 5'd0; id_rs_data_i = 32'h0; id_rt_data_i = 32'h0;
        mi(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_reg_write", {31'h0, reg_write_o}, 32'h0);
        chk("rst_instret", instret_o, 32'h0);
        chk("rst_write_data", write_data_o, 32'h0);
        #1 rst_n = 1'b1;

        @(negedge clk); #1 mi(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 5'd8);
        @(negedge clk);
        chk("alu_reg_write", {31'h0, reg_write_o}, 32'h1);
        chk("alu_rd", {27'h0, rd_o}, 32'd8);
        chk("alu_data", write_data_o, 32'h1234_5678);
        chk("alu_retire", {31'h0, retire_o}, 32'h1);
        #1 mi(1'b1, 1'b1, 1'b1, 3'd3, 2'd0, 32'h0, 32'h80FF_7F01, 5'd1);
        @(negedge clk);
        chk("instret_one", instret_o, 32'd1);
        chk("lb_off0", write_data_o, 32'hFFFF_FF80);
        #1 mi(1'b1, 1'b1, 1'b1, 3'd4, 2'd1, 32'h0, 32'h80FF_7F01, 5'd2);
        @(negedge clk); chk("lbu_off1", write_data_o, 32'h0000_00FF);
        #1 mi(1'b1, 1'b1, 1'b1, 3'd1, 2'd2, 32'h0, 32'h80FF_7F01, 5'd2);
        @(negedge clk); chk("lh_off2", write_data_o, 32'h0000_7F01);
        #1 mi(1'b1, 1'b1, 1'b1, 3'd2, 2'd0, 32'h0, 32'h80FF_7F01, 5'd2);
        @(negedge clk); chk("lhu_off0", write_data_o, 32'h0000_80FF);
        #1 mi(1'b1, 1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'h80FF_7F01, 5'd2);
        @(negedge clk); chk("lw_off0", write_data_o, 32'h80FF_7F01);
        #1 mi(1'b1, 1'b1, 1'b1, 3'd0, 2'd2, 32'h0, 32'h80FF_7F01, 5'd3);
        id_rs_i = 5'd3; id_rs_data_i = 32'h0000_0055;
        @(negedge clk);
        chk("mis_flag", {31'h0, misaligned_o}, 32'h1);
        chk("mis_no_write", {31'h0, reg_write_o}, 32'h0);
        chk("mis_retire", {31'h0, retire_o}, 32'h1);
        chk("mis_no_bypass", id_rs_data_o, 32'h0000_0055);
        #1 mi(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0077, 32'h0, 5'd0);
        @(negedge clk); chk("rd0_no_write", {31'h0, reg_write_o}, 32'h0);
        #1 mi(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 5'd9);
        id_rs_i = 5'd9; id_rs_data_i = 32'h0; id_rt_i = 5'd10; id_rt_data_i = 32'h0000_1111;
        @(negedge clk);
        chk("byp_rs", id_rs_data_o, 32'hDEAD_BEEF);
        chk("byp_rt_pass", id_rt_data_o, 32'h0000_1111);
        #1 mi(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_FFFF, 32'h0, 5'd0);
        id_rs_i = 5'd0; id_rs_data_i = 32'h0;
        @(negedge clk); chk("byp_zero", id_rs_data_o, 32'h0);

        #1 mi(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_A5A5, 32'h0, 5'd5);
        @(negedge clk);
        #1 stall = 1'b1; mi(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_no_write", {31'h0, reg_write_o}, 32'h0);
            chk("stall_hold_rd", {27'h0, rd_o}, 32'd5);
            chk("stall_hold_data", write_data_o, 32'h0000_A5A5);
        end
        #1 stall = 1'b0;
        #1 chk("release_write", {31'h0, reg_write_o}, 32'h1);
        @(negedge clk); chk("release_once", {31'h0, reg_write_o}, 32'h0);

        #1 mi(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0066, 32'h0, 5'd6);
        @(negedge clk);
        #1 flush = 1'b1; stall = 1'b1; mi(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
        #1 chk("fs_no_retire", {31'h0, retire_o}, 32'h0);
        @(negedge clk);
        #1 flush = 1'b0; stall = 1'b0;
        #1 chk("fs_bubble", {31'h0, retire_o}, 32'h0);

        #1 mi(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0001, 32'h0, 5'd7);
        @(negedge clk);
        #1 force dut.instret_r = 32'hFFFF_FFFF;
        m_adj = 32'hFFFF_FFFF - m_cnt;
        #1 release dut.instret_r;
        mi(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
        @(negedge clk); chk("instret_wrap", instret_o, 32'h0);

        #1 mi(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_CAFE, 32'h0, 5'd4);
        id_rs_i = 5'd4; id_rs_data_i = 32'h0000_1234;
        @(negedge clk);
        @(posedge clk);
        #2 m_adj = 32'h0; rst_n = 1'b0;
        #1;
        chk("arst_reg_write", {31'h0, reg_write_o}, 32'h0);
        chk("arst_rd", {27'h0, rd_o}, 32'h0);
        chk("arst_data", write_data_o, 32'h0);
        chk("arst_retire", {31'h0, retire_o}, 32'h0);
        chk("arst_instret", instret_o, 32'h0);
        chk("arst_rs", id_rs_data_o, 32'h0);
        chk("arst_rt", id_rt_data_o, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1; mi(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            mi(($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
               5'($urandom_range(0, 3)));
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            id_rs_i = 5'($urandom_range(0, 3));
            id_rt_i = 5'($urandom_range(0, 3));
            id_rs_data_i = $urandom;
            id_rt_data_i = $urandom;
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
